pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the architectural PC and sequences instruction fetch for the RV32IM core.
//  Consumes resolved redirect requests from branch control (taken branch, JAL, JALR target).
//  Generates pipeline flushes and traps misaligned targets. Sits between branch control,
//  the hazard unit and instruction memory.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset
//  TRAP_VEC      32'h0000_0100  PC loaded on misaligned-target trap
//  FLUSH_CYCLES  2              bubble cycles after a redirect (>=1)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   synchronous, active-high reset
//  stall_i          in   1   hazard-unit stall; hold PC
//  redirect_valid   in   1   branch control reports taken branch or jump
//  redirect_target  in   32  next PC from branch control
//  imem_ready       in   1   instruction memory accepts fetch at pc_o this cycle
//  pc_o             out  32  current fetch address
//  fetch_valid      out  1   pc_o is a live fetch request
//  flush_if_id      out  1   squash IF/ID register
//  flush_id_ex      out  1   squash ID/EX register
//  misalign_trap    out  1   one-cycle pulse: redirect target not word-aligned
//  trap_pc          out  32  faulting target latched at trap
//  redirect_count   out  32  accepted redirects, wraps at 2^32
// BEHAVIOUR
//  Reset: pc_o=RESET_PC, state=RUN, fetch_valid=0 during reset and 1 after.
//   All other outputs reset to 0.
//  All outputs are registered. No combinational path from inputs to outputs.
//  States: RUN, FLUSH, TRAP. Priority in RUN: redirect > stall_i > imem_ready.
//  RUN behaviour:
//   - redirect_valid with target[1:0]==0: pc_o<=target and redirect_count++.
//     Flush outputs go to 1 on the next cycle. cnt<=FLUSH_CYCLES-1, go to FLUSH.
//   - redirect_valid with target[1:0]!=0: trap_pc<=target, pc_o held, go to TRAP.
//     redirect_count is not incremented.
//   - otherwise, with !stall_i && imem_ready: pc_o<=pc_o+4, wrapping mod 2^32.
//   - otherwise: pc_o held.
//  FLUSH behaviour:
//   - flush_if_id and flush_id_ex are 1 for exactly FLUSH_CYCLES cycles.
//   - redirect_valid and stall_i are ignored (they come from squashed instructions).
//   - pc_o advances by 4 only when imem_ready.
//   - cnt decrements each cycle. When cnt==0, go to RUN.
//  TRAP behaviour (one cycle):
//   - misalign_trap=1, pc_o<=TRAP_VEC, cnt<=FLUSH_CYCLES-1, go to FLUSH.
//  Counter width is $clog2(FLUSH_CYCLES+1).
//  rst asserted in any state overrides everything. Reset values appear next cycle.
//   A redirect in the same cycle as rst is dropped.
// STRUCTURE
//  pc_seq_pkg holds:
//   - typedef enum logic [1:0] {RUN, FLUSH, TRAP} pc_seq_state_t
//   - localparam PC_STEP = 32'd4
//   - default RESET_PC and TRAP_VEC constants
//  Single module. The flush counter is inline; no sub-module is needed.
// TESTING
//  1. Reset, imem_ready=1, 4 cycles -> pc_o 0,4,8,C; fetch_valid=1; no flushes.
//  2. pc_o=0x10, redirect target 0x40 -> next pc_o=0x40.
//     Flush outputs high for 2 cycles. redirect_count=1. State back to RUN.
//  3. Redirect target 0x42 -> TRAP: misalign_trap pulses once, trap_pc=0x42.
//     Then pc_o=0x100, then a 2-cycle flush. redirect_count unchanged.
//  4. stall_i=1 with redirect_valid=1 (target 0x80) -> redirect wins, pc_o=0x80.
//     Redirect_valid during the following flush is ignored.
//  5. imem_ready=0 for 3 cycles at pc_o=0x20 -> pc_o holds at 0x20, then resumes at 0x24.
//  6. rst asserted during FLUSH -> next cycle pc_o=RESET_PC, flush outputs=0,
//     state RUN, redirect_count=0.
//  7. pc_o=0xFFFF_FFFC, advance -> pc_o wraps to 0x0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Holds the sequencer state encoding and default vectors.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    TRAP
  } pc_seq_state_t;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer.sv
// Architectural PC owner: sequential fetch, redirects,
// post-redirect flush bubbles and misaligned-target traps.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC     = DEF_TRAP_VEC,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        imem_ready,
  output logic [31:0] pc_o,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign_trap,
  output logic [31:0] trap_pc,
  output logic [31:0] redirect_count
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  pc_seq_state_t r_state;
  pc_seq_state_t w_state_nx;

  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [31:0]   r_trap_pc;
  logic [31:0]   w_trap_pc_nx;
  logic [31:0]   r_redir_cnt;
  logic [31:0]   w_redir_cnt_nx;
  logic          r_flush;
  logic          r_trap;
  logic          r_fetch_valid;

  always_comb begin
    w_state_nx     = r_state;
    w_pc_nx        = r_pc;
    w_cnt_nx       = r_cnt;
    w_trap_pc_nx   = r_trap_pc;
    w_redir_cnt_nx = r_redir_cnt;
    unique case (r_state)
      RUN: begin
        if (redirect_valid) begin
          if (redirect_target[1:0] == 2'b00) begin
            w_pc_nx        = redirect_target;
            w_redir_cnt_nx = r_redir_cnt + 32'd1;
            w_cnt_nx       = CNT_INIT;
            w_state_nx     = FLUSH;
          end else begin
            w_trap_pc_nx = redirect_target;
            w_state_nx   = TRAP;
          end
        end else if (!stall_i && imem_ready) begin
          w_pc_nx = r_pc + PC_STEP;
        end
      end
      // Inputs here belong to squashed instructions.
      FLUSH: begin
        if (imem_ready) begin
          w_pc_nx = r_pc + PC_STEP;
        end
        if (r_cnt == '0) begin
          w_state_nx = RUN;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      TRAP: begin
        w_pc_nx    = TRAP_VEC;
        w_cnt_nx   = CNT_INIT;
        w_state_nx = FLUSH;
      end
      default: begin
        w_state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_cnt         <= '0;
      r_trap_pc     <= '0;
      r_redir_cnt   <= '0;
      r_flush       <= 1'b0;
      r_trap        <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_pc          <= w_pc_nx;
      r_cnt         <= w_cnt_nx;
      r_trap_pc     <= w_trap_pc_nx;
      r_redir_cnt   <= w_redir_cnt_nx;
      r_flush       <= (w_state_nx == FLUSH);
      r_trap        <= (w_state_nx == TRAP);
      r_fetch_valid <= 1'b1;
    end
  end

  assign pc_o           = r_pc;
  assign fetch_valid    = r_fetch_valid;
  assign flush_if_id    = r_flush;
  assign flush_id_ex    = r_flush;
  assign misalign_trap  = r_trap;
  assign trap_pc        = r_trap_pc;
  assign redirect_count = r_redir_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random
// traffic, all checked against a cycle-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] TVC = 32'h0000_0100;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_ready;
  logic [31:0] pc_o;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_trap;
  logic [31:0] trap_pc;
  logic [31:0] redirect_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_tpc;
  logic [31:0] m_cnt;
  int          m_fl;
  bit          m_trap;
  bit          m_fv;

  pc_sequencer #(
    .RESET_PC    (RPC),
    .TRAP_VEC    (TVC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_ready     (imem_ready),
    .pc_o           (pc_o),
    .fetch_valid    (fetch_valid),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .misalign_trap  (misalign_trap),
    .trap_pc        (trap_pc),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // m_fl counts flush cycles still to be shown, including the current one.
  task automatic model(input bit r, input bit s, input bit rv,
                       input logic [31:0] t, input bit rd);
    if (r) begin
      m_pc = RPC; m_tpc = 0; m_cnt = 0;
      m_fl = 0; m_trap = 0; m_fv = 0;
    end else begin
      m_fv = 1;
      if (m_trap) begin
        m_pc = TVC; m_trap = 0; m_fl = FC;
      end else if (m_fl > 0) begin
        if (rd) m_pc = m_pc + 4;
        m_fl--;
      end else if (rv) begin
        if (t % 4 == 0) begin
          m_pc = t; m_cnt = m_cnt + 1; m_fl = FC;
        end else begin
          m_tpc = t; m_trap = 1;
        end
      end else if (!s && rd) begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit rv,
                      input logic [31:0] t, input bit rd);
    rst = r; stall_i = s; redirect_valid = rv;
    redirect_target = t; imem_ready = rd;
    @(posedge clk);
    model(r, s, rv, t, rd);
    #1;
    chk("pc", pc_o, m_pc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("flush_if_id", 32'(flush_if_id), 32'(m_fl > 0));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(m_fl > 0));
    chk("misalign", 32'(misalign_trap), 32'(m_trap));
    chk("trap_pc", trap_pc, m_tpc);
    chk("redir_cnt", redirect_count, m_cnt);
  endtask

  initial begin
    m_pc = 0; m_tpc = 0; m_cnt = 0; m_fl = 0; m_trap = 0; m_fv = 0;

    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_pc", pc_o, RPC);
    chk("rst_fv", 32'(fetch_valid), 0);

    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 1);
      chk("t1_pc", pc_o, 32'(4 * i));
      chk("t1_noflush", 32'(flush_if_id), 0);
    end
    chk("t1_fv", 32'(fetch_valid), 1);
    step(0, 0, 0, 0, 1);
    chk("t2_pre", pc_o, 32'h10);

    step(0, 0, 1, 32'h40, 1);
    chk("t2_pc", pc_o, 32'h40);
    chk("t2_fl1", 32'(flush_id_ex), 1);
    chk("t2_cnt", redirect_count, 1);
    step(0, 0, 0, 0, 1);
    chk("t2_fl2", 32'(flush_if_id), 1);
    step(0, 0, 0, 0, 1);
    chk("t2_fl_end", 32'(flush_if_id), 0);
    chk("t2_pc_end", pc_o, 32'h48);

    step(0, 0, 1, 32'h42, 1);
    chk("t3_trap", 32'(misalign_trap), 1);
    chk("t3_tpc", trap_pc, 32'h42);
    step(0, 0, 0, 0, 1);
    chk("t3_vec", pc_o, 32'h100);
    chk("t3_pulse", 32'(misalign_trap), 0);
    chk("t3_fl", 32'(flush_if_id), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t3_fl_end", 32'(flush_if_id), 0);
    chk("t3_cnt", redirect_count, 1);

    step(0, 1, 1, 32'h80, 1);
    chk("t4_pc", pc_o, 32'h80);
    step(0, 0, 1, 32'h200, 1);
    chk("t4_ign", pc_o, 32'h84);
    chk("t4_cnt", redirect_count, 2);
    step(0, 0, 0, 0, 1);

    step(0, 0, 1, 32'h20, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_hold", pc_o, 32'h20);
    step(0, 0, 0, 0, 1);
    chk("t5_resume", pc_o, 32'h24);

    step(0, 0, 1, 32'h300, 1);
    step(1, 0, 1, 32'h400, 1);
    chk("t6_pc", pc_o, RPC);
    chk("t6_fl", 32'(flush_if_id), 0);
    chk("t6_cnt", redirect_count, 0);
    step(0, 0, 0, 0, 1);
    chk("t6_run", pc_o, 32'h4);

    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0, 1);
    chk("t7_wrap", pc_o, 32'h0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 9) < 7) t[1:0] = 2'b00;
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           t,
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
